// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg: shared defaults and types for the GPIO debounce stage
package gpio_debounce_pkg;
  localparam int TICK_DIV_DEFAULT = 50000;
  localparam int STABLE_TICKS_DEFAULT = 10;
  typedef logic [3:0] dbc_cnt_t;
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;
endpackage

// File: rtl/gpio_debounce_if.sv
// gpio_debounce_if: switch inputs, per-bit controls and conditioned outputs
interface gpio_debounce_if #(parameter int WIDTH = 16);
  import gpio_debounce_pkg::*;
  logic [WIDTH-1:0] i_raw, i_irq_en, i_clr, o_stable, o_rise, o_fall, o_pending;
  logic o_irq, o_armed;
  modport master(output i_raw, i_irq_en, i_clr, input o_stable, o_rise, o_fall, o_pending, o_irq, o_armed);
  modport slave(input i_raw, i_irq_en, i_clr, output o_stable, o_rise, o_fall, o_pending, o_irq, o_armed);
endinterface

// File: rtl/gpio_debounce_bit.sv
// debounce_bit: synchroniser, tick-counted stability window and edge pulse for one input
module debounce_bit import gpio_debounce_pkg::*; #(
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  raw,
  input  logic  tick,
  input  logic  armed,
  output logic  stable,
  output edge_t pulse
);
  localparam dbc_cnt_t LAST = dbc_cnt_t'(STABLE_TICKS - 1);
  logic [SYNC_STAGES-1:0] sync;
  dbc_cnt_t cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
      pulse  <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      pulse <= '0;
      if (s == stable) cnt <= '0;
      else if (tick && cnt == LAST) begin
        stable <= s;
        cnt    <= '0;
        pulse  <= {armed & s, armed & ~s};
      end else if (tick) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-bit debounce with shared prescaler, arming delay, sticky pending and irq
module gpio_debounce import gpio_debounce_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rstn,
  gpio_debounce_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pre;
  logic [4:0] arm_cnt;
  logic tick, armed, irq;
  logic [WIDTH-1:0] stable, rise, fall, pending;
  edge_t pulse [WIDTH];
  assign tick = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pre     <= '0;
      arm_cnt <= '0;
      armed   <= 1'b0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pre     <= tick ? '0 : pre + 1'b1;
      arm_cnt <= (tick && !armed) ? arm_cnt + 1'b1 : arm_cnt;
      armed   <= armed | (tick && arm_cnt == 5'(STABLE_TICKS));
      pending <= (pending & ~bus.i_clr) | rise | fall;
      irq     <= |(pending & bus.i_irq_en);
    end
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_bit (
      .clk(clk), .rstn(rstn), .raw(bus.i_raw[g]), .tick(tick), .armed(armed),
      .stable(stable[g]), .pulse(pulse[g])
    );
    assign rise[g] = pulse[g].rise;
    assign fall[g] = pulse[g].fall;
  end
  assign bus.o_stable  = stable;
  assign bus.o_rise    = rise;
  assign bus.o_fall    = fall;
  assign bus.o_pending = pending;
  assign bus.o_irq     = irq;
  assign bus.o_armed   = armed;
endmodule
